// File: rtl/aes_pkg.sv
// Shared AES key-expansion types, round constants and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON [1:NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] r;
    r = '0;
    for (int k = 1; k <= NUM_ROUNDS; k++)
      if (idx == 4'(k)) r = RCON[k];
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128, so zero maps to zero
  always_comb begin
    sq  = data;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign sub = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key expansion, one round key per cycle into key_mem[0..10].
// Optional AES_KEY_ZEROIZE_EN enables the zeroize key-erase input.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic [4:0]   read_addr,
  input  logic         zeroize,
  output logic [127:0] round_key_0,
  output logic [127:0] round_key_input,
  output logic         key_ready,
  output logic         busy
);

  logic [127:0] key_mem [0:NUM_ROUNDS];
  state_t       state;
  state_t       state_next;
  logic [3:0]   cnt;
  logic         wipe;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  tw;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;

`ifdef AES_KEY_ZEROIZE_EN
  assign wipe = zeroize;
`else
  logic unused_zeroize;
  assign unused_zeroize = zeroize;
  assign wipe = 1'b0;
`endif

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (cnt == 4'(i + 1)) prev_key = key_mem[i];
  end

  assign rot = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot[8*g +: 8]),
      .sub  (sub[8*g +: 8])
    );
  end

  assign tw = sub ^ {rcon_lookup(cnt), 24'h0};
  assign w0 = prev_key[127:96] ^ tw;
  assign w1 = prev_key[95:64] ^ w0;
  assign w2 = prev_key[63:32] ^ w1;
  assign w3 = prev_key[31:0] ^ w2;
  assign next_key = {w0, w1, w2, w3};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (wipe)
      state_next = IDLE;
    else if (key_load)
      state_next = EXPAND;
    else if (state == EXPAND && cnt == 4'(NUM_ROUNDS))
      state_next = READY;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_mem[i] <= '0;
    end else if (wipe) begin
      cnt <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_mem[i] <= '0;
    end else if (key_load) begin
      cnt        <= 4'd1;
      key_mem[0] <= key_in;
    end else if (state == EXPAND) begin
      for (int i = 1; i <= NUM_ROUNDS; i++)
        if (cnt == 4'(i)) key_mem[i] <= next_key;
      cnt <= (cnt == 4'(NUM_ROUNDS)) ? 4'd0 : cnt + 4'd1;
    end
  end

  // Out-of-range indices read as zero
  always_comb begin
    round_key_input = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (read_addr == 5'(i)) round_key_input = key_mem[i];
  end

  assign round_key_0 = key_mem[0];
  assign key_ready   = (state == READY);
  assign busy        = (state == EXPAND);

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion (FIPS-197 vectors and corner cases).
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [4:0]   read_addr = '0;
  logic         zeroize = 1'b0;
  logic [127:0] round_key_0;
  logic [127:0] round_key_input;
  logic         key_ready;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [2];

  aes_key_expansion dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .key_load        (key_load),
    .key_in          (key_in),
    .read_addr       (read_addr),
    .zeroize         (zeroize),
    .round_key_0     (round_key_0),
    .round_key_input (round_key_input),
    .key_ready       (key_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (!key_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [127:0] v);
    read_addr = a;
    #1;
    v = round_key_input;
  endtask

  initial begin
    int n;
    logic [127:0] v;

    vecs[0] = '{FIPS_KEY, FIPS_RK1, FIPS_RK10};
    vecs[1] = '{128'h0, ZERO_RK1, ZERO_RK10};

    repeat (2) @(negedge clk);
    chk("reset_rk0", round_key_0, 128'h0);
    chk("reset_ready", 128'(key_ready), 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    n_rst = 1'b1;

    for (int i = 0; i < 2; i++) begin
      load(vecs[i].key);
      chk("busy_after_load", 128'(busy), 128'h1);
      wait_ready(n);
      chk("latency", 128'(n), 128'd11);
      chk("busy_done", 128'(busy), 128'h0);
      chk("rk0_port", round_key_0, vecs[i].key);
      rd(5'd0, v);  chk("rk_addr0", v, vecs[i].key);
      rd(5'd1, v);  chk("rk_addr1", v, vecs[i].rk1);
      rd(5'd10, v); chk("rk_addr10", v, vecs[i].rk10);
      rd(5'd11, v); chk("rk_addr11", v, 128'h0);
      rd(5'd31, v); chk("rk_addr31", v, 128'h0);
    end

    load(128'h0);
    repeat (3) begin
      @(negedge clk);
      chk("restart_busy", 128'(busy), 128'h1);
    end
    load(FIPS_KEY);
    chk("restart_busy2", 128'(busy), 128'h1);
    wait_ready(n);
    chk("restart_latency", 128'(n), 128'd11);
    chk("restart_rk0", round_key_0, FIPS_KEY);
    rd(5'd1, v);  chk("restart_rk1", v, FIPS_RK1);
    rd(5'd10, v); chk("restart_rk10", v, FIPS_RK10);

    load(FIPS_KEY);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    rd(5'd1, v);
    chk("rst_mid_rk1", v, 128'h0);
    chk("rst_mid_rk0", round_key_0, 128'h0);
    chk("rst_mid_ready", 128'(key_ready), 128'h0);
    chk("rst_mid_busy", 128'(busy), 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_after_ready", 128'(key_ready), 128'h0);
    chk("rst_after_busy", 128'(busy), 128'h0);
    rd(5'd10, v); chk("rst_after_rk10", v, 128'h0);

    load(128'h0);
    wait_ready(n);
    @(negedge clk);
    key_in   = FIPS_KEY;
    key_load = 1'b1;
    zeroize  = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    zeroize  = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
    chk("zero_busy", 128'(busy), 128'h0);
    chk("zero_ready", 128'(key_ready), 128'h0);
    chk("zero_rk0", round_key_0, 128'h0);
    rd(5'd10, v); chk("zero_rk10", v, 128'h0);
    repeat (12) @(negedge clk);
    chk("zero_stays_idle", 128'(busy | key_ready), 128'h0);
`else
    chk("nozero_busy", 128'(busy), 128'h1);
    wait_ready(n);
    chk("nozero_latency", 128'(n), 128'd11);
    chk("nozero_rk0", round_key_0, FIPS_KEY);
    rd(5'd1, v);  chk("nozero_rk1", v, FIPS_RK1);
    rd(5'd10, v); chk("nozero_rk10", v, FIPS_RK10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_load, input, 1 bit: a one-cycle pulse that starts expansion of key_in.
REQ-004 SHALL have port key_in, input, 128 bits: the AES-128 cipher key, byte 0 in bits [127:120].
REQ-005 SHALL have port read_addr, input, 5 bits: the round-key index requested by the AES engine.
REQ-006 SHALL have port zeroize, input, 1 bit: a key-erase request, effective only with AES_KEY_ZEROIZE_EN.
REQ-007 SHALL have port round_key_0, output, 128 bits: stored round key 0.
REQ-008 SHALL have port round_key_input, output, 128 bits: the stored round key selected by read_addr.
REQ-009 SHALL have port key_ready, output, 1 bit: high when all 11 round keys are valid.
REQ-010 SHALL have port busy, output, 1 bit: high while expansion is in progress.

Function
REQ-011 SHALL hold 11 128-bit registers, key_mem[0..10].
REQ-012 SHALL implement FSM states IDLE, EXPAND and READY.
REQ-013 SHALL, on key_load in any state, write key_in to key_mem[0], set round counter to 1, drop key_ready and go to EXPAND.
REQ-014 SHALL, in each EXPAND cycle, compute key_mem[i] from key_mem[i-1] using the FIPS-197 schedule: RotWord, then SubWord, then XOR Rcon[i] on word 0, then the chained XOR of words 1-3.
REQ-015 SHALL use Rcon values 01,02,04,08,10,20,40,80,1B,36 for i = 1..10, placed in the top byte of the word.
REQ-016 SHALL move to READY after writing key_mem[10], set key_ready=1 and busy=0.
REQ-017 SHALL give a latency of exactly 11 rising edges from the edge that samples key_load to the edge after which key_ready=1.
REQ-018 SHALL, when key_load is asserted during EXPAND, abort the current expansion and restart with the new key_in.
REQ-019 SHALL drive round_key_input combinationally as key_mem[read_addr] for read_addr 0..10, and as 0 for read_addr 11..31.
REQ-020 SHALL drive round_key_0 as key_mem[0] at all times.
REQ-021 SHALL let reads during EXPAND return current register contents; consumers qualify reads with key_ready.
REQ-022 SHALL drive busy=1 exactly when the state is EXPAND.

Reset
REQ-023 SHALL, while n_rst=0, asynchronously clear all key_mem registers to 0, set state to IDLE, set the counter to 0 and set key_ready=0 and busy=0.
REQ-024 SHALL, when reset is asserted mid-expansion, discard all partial keys; operation resumes only on a new key_load.

Configuration
REQ-025 SHALL, with AES_KEY_ZEROIZE_EN defined, respond to zeroize=1 at a clock edge by clearing all key_mem registers, going to IDLE and dropping key_ready and busy.
REQ-026 SHALL give zeroize priority over a simultaneous key_load.
REQ-027 SHALL, without AES_KEY_ZEROIZE_EN, ignore zeroize; the port remains present and unused.

Structure
REQ-028 SHALL take from shared package aes_pkg: the state enum typedef, the constant NUM_ROUNDS=10 and the Rcon lookup table.
REQ-029 SHALL instantiate four copies of sub-module aes_sbox (8-bit combinational forward S-box) to implement SubWord.

Verification
REQ-030 SHALL cover: key_load with key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready after 11 edges; read_addr=1 gives a0fafe1788542cb123a339392a6c7605; read_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 SHALL cover: an all-zero key -> read_addr=1 gives 62636363626363636263636362636363; read_addr=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 SHALL cover: a second key_load 4 cycles into expansion -> busy stays high; key_ready rises 11 edges after the second load; keys match the second key only.
REQ-033 SHALL cover: n_rst pulsed low at expansion cycle 5 -> all outputs 0; no key_ready until a new key_load.
REQ-034 SHALL cover: read_addr=11 and read_addr=31 in READY -> round_key_input=0.
REQ-035 SHALL cover, with AES_KEY_ZEROIZE_EN: zeroize together with key_load -> key_mem all 0, state IDLE, key_ready=0; without the macro the same stimulus performs a normal load.
